// File: rtl/conv_engine.sv
// rtl/conv_engine.sv - sequential 3x3 convolution engine with start/done handshake
module conv_engine #(
  parameter int          DATA_W = 8,
  parameter logic [71:0] KERNEL = 72'h00_FF_00_FF_05_FF_00_FF_00,
  parameter int          SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              shift_right,
  input  logic              start_conv,
  output logic              done_conv,
  output logic [DATA_W-1:0] result
);

  // 9 taps of (DATA_W+1)-bit signed x 8-bit signed products never overflow this width
  localparam int ACC_W  = DATA_W + 13;
  localparam int PROD_W = DATA_W + 9;
  localparam logic signed [ACC_W-1:0] MAX_PIX = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} state_t;

  state_t                   state;
  logic [DATA_W-1:0]        w [9];
  logic signed [ACC_W-1:0]  acc;
  logic [3:0]               idx;

  logic [DATA_W-1:0]        tap_pix;
  logic signed [7:0]        tap_coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        sat_val;

  // Select the current tap's pixel and coefficient, form the product and the clamped result
  always_comb begin
    tap_pix  = '0;
    tap_coef = '0;
    for (int k = 0; k < 9; k++) begin
      if (idx == 4'(k)) begin
        tap_pix  = w[k];
        tap_coef = KERNEL[8*k +: 8];
      end
    end
    prod    = PROD_W'($signed({1'b0, tap_pix})) * PROD_W'(tap_coef);
    shifted = acc >>> SHIFT;
    if (shifted[ACC_W-1]) begin
      sat_val = '0;
    end else if (shifted > MAX_PIX) begin
      sat_val = '1;
    end else begin
      sat_val = shifted[DATA_W-1:0];
    end
  end

  // Window shifting plus the IDLE/MAC/SAT/DONE sequencer; the window is frozen during MAC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      done_conv <= 1'b0;
      result    <= '0;
      for (int k = 0; k < 9; k++) begin
        w[k] <= '0;
      end
    end else begin
      if (shift_right && state != MAC) begin
        for (int k = 0; k < 8; k++) begin
          w[k] <= w[k+1];
        end
        w[8] <= pixel_in;
      end
      case (state)
        IDLE: begin
          if (start_conv) begin
            state <= MAC;
            acc   <= '0;
            idx   <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + 4'd1;
          if (idx == 4'd8) begin
            state <= SAT;
          end
        end
        SAT: begin
          result    <= sat_val;
          done_conv <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (!start_conv) begin
            done_conv <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// tb/tb_conv_engine.sv - scoreboard bench for conv_engine, default and single-tap kernels
module tb_conv_engine;

  localparam logic [71:0] K_A = 72'h00_FF_00_FF_05_FF_00_FF_00;
  localparam logic [71:0] K_B = 72'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shift_right = 1'b0;
  logic       start_conv = 1'b0;
  logic [7:0] pixel_in = '0;
  logic       done_a, done_b;
  logic [7:0] result_a, result_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int win [9];

  typedef struct {
    int res;
    int due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   prev_a = 1'b0;
  bit   prev_b = 1'b0;

  conv_engine #(.DATA_W(8), .KERNEL(K_A), .SHIFT(0)) u_a (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .shift_right(shift_right),
    .start_conv(start_conv), .done_conv(done_a), .result(result_a)
  );

  conv_engine #(.DATA_W(8), .KERNEL(K_B), .SHIFT(0)) u_b (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .shift_right(shift_right),
    .start_conv(start_conv), .done_conv(done_b), .result(result_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: dot product of the pixel window with the kernel, then clamp to 0..255
  function automatic int model(input logic [71:0] kern);
    int  sum;
    byte c;
    sum = 0;
    for (int k = 0; k < 9; k++) begin
      c = kern[8*k +: 8];
      sum += win[k] * int'(c);
    end
    if (sum < 0) return 0;
    if (sum > 255) return 255;
    return sum;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_pix(input int p);
    pixel_in = 8'(p);
    shift_right = 1'b1;
    tick();
    shift_right = 1'b0;
    for (int k = 0; k < 8; k++) win[k] = win[k+1];
    win[8] = p;
  endtask

  // One full handshake; pulse>0 injects a shift on that MAC edge, which must be ignored
  task automatic run_conv(input int hold, input int pulse, input bit prefetch);
    int ea, eb, n;
    ea = model(K_A);
    eb = model(K_B);
    start_conv = 1'b1;
    tick();
    qa.push_back('{ea, cyc + 10});
    qb.push_back('{eb, cyc + 10});
    n = 0;
    while (!done_a && n < 20) begin
      if (n + 1 == pulse) begin
        pixel_in = 8'd200;
        shift_right = 1'b1;
      end
      tick();
      shift_right = 1'b0;
      n++;
    end
    chk("done_timeout", int'(done_a), 1);
    for (int h = 0; h < hold; h++) begin
      if (prefetch) shift_pix(int'($urandom_range(0, 255)));
      else tick();
      chk("hold_done_a", int'(done_a), 1);
      chk("hold_done_b", int'(done_b), 1);
      chk("hold_result_a", int'(result_a), ea);
      chk("hold_result_b", int'(result_b), eb);
    end
    start_conv = 1'b0;
    tick();
    chk("drop_done_a", int'(done_a), 0);
    chk("drop_done_b", int'(done_b), 0);
  endtask

  // Monitor: every rising done_conv consumes one scoreboard entry and checks value and latency
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_a = 1'b0;
      prev_b = 1'b0;
    end else begin
      if (done_a && !prev_a) begin
        if (qa.size() == 0) chk("unexpected_done_a", 1, 0);
        else begin
          e = qa.pop_front();
          chk("result_a", int'(result_a), e.res);
          chk("latency_a", cyc, e.due);
        end
      end
      if (done_b && !prev_b) begin
        if (qb.size() == 0) chk("unexpected_done_b", 1, 0);
        else begin
          e = qb.pop_front();
          chk("result_b", int'(result_b), e.res);
          chk("latency_b", cyc, e.due);
        end
      end
      prev_a = done_a;
      prev_b = done_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 9; k++) win[k] = 0;

    tick();
    tick();
    chk("reset_done_a", int'(done_a), 0);
    chk("reset_result_a", int'(result_a), 0);
    chk("reset_done_b", int'(done_b), 0);
    chk("reset_result_b", int'(result_b), 0);
    rst = 1'b0;
    tick();

    // Uniform window of 10, start held 3 cycles past done while the next window prefetches
    for (int i = 0; i < 9; i++) shift_pix(10);
    run_conv(3, 0, 1'b1);
    for (int i = 0; i < 6; i++) shift_pix(int'($urandom_range(0, 255)));
    run_conv(0, 0, 1'b0);

    // Positive saturation (sum 1275) and negative clamp (sum -400)
    for (int i = 0; i < 9; i++) shift_pix(i == 4 ? 255 : 0);
    run_conv(0, 0, 1'b0);
    for (int i = 0; i < 9; i++) shift_pix(i % 2 == 1 ? 100 : 0);
    run_conv(1, 0, 1'b0);

    // Ordering and MAC freeze: window 1..9 with a shift attempted during MAC
    for (int i = 1; i <= 9; i++) shift_pix(i);
    run_conv(0, 5, 1'b0);
    run_conv(0, 2, 1'b0);
    for (int i = 7; i <= 15; i++) shift_pix(i);
    run_conv(0, 0, 1'b0);

    // Random windows with random hold lengths and occasional prefetch during DONE
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 9; i++) shift_pix(int'($urandom_range(0, 255)));
      run_conv(int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of MAC
    for (int i = 0; i < 9; i++) shift_pix(int'($urandom_range(0, 255)));
    start_conv = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_done_a", int'(done_a), 0);
    chk("async_rst_result_a", int'(result_a), 0);
    chk("async_rst_done_b", int'(done_b), 0);
    chk("async_rst_result_b", int'(result_b), 0);
    start_conv = 1'b0;
    for (int k = 0; k < 9; k++) win[k] = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("post_rst_idle_a", int'(done_a), 0);
      chk("post_rst_idle_b", int'(done_b), 0);
    end
    run_conv(0, 0, 1'b0);

    tick();
    tick();
    chk("sb_empty_a", qa.size(), 0);
    chk("sb_empty_b", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
# conv_engine

Sequential 3x3 convolution engine that answers the `start_conv`/`done_conv` handshake issued by the image-scan control FSM. It captures the nine window pixels streamed from image memory on `shift_right` and multiply-accumulates them against a fixed signed kernel, one tap per cycle. It then saturates the sum to an 8-bit pixel, presents it on `result` and raises `done_conv`. It sits between the input image RAM read port and the output-pixel writer.

## Interface
- `DATA_W`, 8: pixel width, unsigned.
- `KERNEL`, 72'h00_FF_00_FF_05_FF_00_FF_00: nine packed signed 8-bit coefficients.
  - Coefficient k occupies bits [8k+7:8k].
  - Default is a sharpen kernel: 0,-1,0,-1,5,-1,0,-1,0.
- `SHIFT`, 0: arithmetic right shift applied to the accumulator before clamping.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pixel_in` in DATA_W: image memory read data.
- `shift_right` in 1: shift `pixel_in` into the window this edge.
- `start_conv` in 1: convolution request, level, 4-phase handshake.
- `done_conv` out 1: result ready, held until `start_conv` drops.
- `result` out DATA_W: saturated convolution output.

## Operation
- **Window:** nine registers w[0..8].
  - On an edge with `shift_right`=1, outside MAC: w[8]<=`pixel_in`, w[k]<=w[k+1].
  - After nine shifts, w[0] holds the first pixel shifted (top-left) and w[8] the last (bottom-right).
  - Coefficient k multiplies w[k].
  - Aligning `pixel_in` to `shift_right` for memory read latency is the controller's job. The engine samples blindly.
- **States:** IDLE, MAC, SAT, DONE.
  - IDLE: on `start_conv`=1, go to MAC, acc<=0, idx<=0.
  - MAC: acc <= acc + signed({1'b0,w[idx]}) * k[idx], idx<=idx+1. When idx==8, go to SAT. `shift_right` is ignored in this state.
  - SAT: result <= clamp(acc >>> SHIFT, 0, 255), done_conv<=1, go to DONE.
  - DONE: hold `result` and `done_conv`=1 while `start_conv`=1. On an edge with `start_conv`=0: done_conv<=0, go to IDLE.
  - Shifts are accepted in DONE, so the controller may prefetch the next window.
- **Arithmetic:**
  - Product: 9-bit signed times 8-bit signed gives 17 bits.
  - Accumulator: 21-bit signed, so no overflow is possible: |sum| ≤ 9·255·128.
  - Clamp: negative values give 0; values >255 give 255; otherwise the low 8 bits.
- **Handshake:**
  - `start_conv` still high in the cycle after `done_conv` rises never starts a second computation.
  - A new computation starts only after a return to IDLE with `start_conv` sampled high.
- **Undefined encodings:** any unused state encoding goes to IDLE.

## Timing
- **Reset values:** `done_conv`=0, `result`=0, state IDLE, w[0..8]=0, acc=0, idx=0.
  - `rst` mid-operation clears everything immediately, asynchronously.
  - A pending request is lost; the controller must re-issue it.
- **Latency:**
  - Edge E0 samples `start_conv`=1 in IDLE.
  - Edges E1–E9 perform the nine MACs.
  - Edge E10 (SAT) updates `result` and raises `done_conv`.
  - `done_conv` is high 10 edges after the sampling edge. `result` is valid in the same cycle and stable until the next SAT.
- **Deassertion:** `done_conv` falls on the first edge where `start_conv`=0 is sampled in DONE.
- **Throughput:** minimum one convolution per 12 cycles plus 9 shift cycles. Shifts may overlap DONE.
- **Registered outputs:** all outputs are registered; no combinational input-to-output path.

## Test plan
- **Reset:** assert `rst` at E5 of a computation.
  - Required: `done_conv`=0 and `result`=0 within the same cycle.
  - Required: after release, the engine stays idle until a new `start_conv`.
- **Uniform window:** shift nine pixels of 10, default KERNEL, pulse `start_conv`.
  - Required: `result`=10.
  - Required: `done_conv` rises exactly 10 edges after the sampling edge.
- **Positive saturation:** shift 0,0,0,0,255,0,0,0,0.
  - Required: acc=1275, `result`=255.
- **Negative clamp:** shift 0,100,0,100,0,100,0,100,0.
  - Required: acc=-400, `result`=0.
- **Ordering and MAC freeze:** KERNEL=72'h01 (only k0=1), shift 1..9, start, and pulse `shift_right` with `pixel_in`=200 during MAC.
  - Required: `result`=1; the pixel shifted during MAC is not captured.
  - Then shift 9 more pixels starting with 7.
  - Required: next `result`=7.
- **Handshake hold:** keep `start_conv` high 3 cycles after `done_conv`.
  - Required: `done_conv` stays 1 and `result` is unchanged with no restart.
  - Drop `start_conv`. Required: `done_conv`=0 on the next edge.
  - Re-raise `start_conv`. Required: a fresh computation completes 10 edges later.
